// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: operand buffers plus a sequencer that feeds a Q6.10 MAC.
// It issues one clear cycle and then one operand pair per cycle. It captures the
// MAC result and presents it on a valid/ready output port.
// Optional feature: define DOTSEQ_PERF_CNT_EN to add the o_perf_ops handshake counter.
module dot_product_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic              i_wr_sel,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_vec_len,
    output logic              o_busy,
    output logic              o_mac_enable,
    output logic              o_mac_clear,
    output logic [DATA_W-1:0] o_mac_a,
    output logic [DATA_W-1:0] o_mac_b,
    input  logic [DATA_W-1:0] i_mac_result,
    output logic              o_out_valid,
    input  logic              i_out_ready,
`ifdef DOTSEQ_PERF_CNT_EN
    output logic [DATA_W-1:0] o_out_data,
    output logic [31:0]       o_perf_ops
`else
    output logic [DATA_W-1:0] o_out_data
`endif
);

    typedef enum logic [2:0] {StIdle, StClear, StRun, StWait, StDone} state_e;

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    state_e              r_state;
    state_e              w_state_d;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     r_len;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [DATA_W-1:0]   r_buf_a [DEPTH];
    logic [DATA_W-1:0]   r_buf_b [DEPTH];
    logic [ADDR_W:0]     w_len_clamped;
    logic                w_last;
    logic                w_handshake;

    assign w_len_clamped = (i_vec_len > LEN_MAX) ? LEN_MAX : i_vec_len;
    assign w_last        = ({1'b0, r_idx} == (r_len - LEN_ONE));
    assign w_handshake   = r_out_valid && i_out_ready;
    assign o_busy        = (r_state != StIdle);
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;

    // Operand buffers: writable only while idle, so a running sum never sees a torn vector.
    always_ff @(posedge clk) begin
        if (i_wr_en && (r_state == StIdle)) begin
            if (i_wr_sel) begin
                r_buf_b[i_wr_addr] <= i_wr_data;
            end else begin
                r_buf_a[i_wr_addr] <= i_wr_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and MAC drive, decoded from registers only (no input-to-MAC path).
    always_comb begin
        w_state_d    = r_state;
        o_mac_enable = 1'b0;
        o_mac_clear  = 1'b0;
        o_mac_a      = '0;
        o_mac_b      = '0;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_d = StClear;
            end
            StClear: begin
                o_mac_enable = 1'b1;
                o_mac_clear  = 1'b1;
                w_state_d    = (r_len != '0) ? StRun : StWait;
            end
            StRun: begin
                o_mac_enable = 1'b1;
                o_mac_a      = r_buf_a[r_idx];
                o_mac_b      = r_buf_b[r_idx];
                if (w_last) w_state_d = StWait;
            end
            StWait: begin
                w_state_d = StDone;
            end
            StDone: begin
                if (w_handshake) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Run bookkeeping and the registered result port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_len       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_len <= w_len_clamped;
                        r_idx <= '0;
                    end
                end
                StRun: r_idx <= r_idx + IDX_ONE;
                StWait: begin
                    // MAC result is registered, so the last product has landed by now.
                    r_out_data  <= i_mac_result;
                    r_out_valid <= 1'b1;
                end
                StDone: begin
                    if (w_handshake) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef DOTSEQ_PERF_CNT_EN
    // Count accepted results; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_ops <= '0;
        end else if (w_handshake) begin
            o_perf_ops <= o_perf_ops + 32'd1;
        end
    end
`endif

endmodule
